// File: rtl/register_file_mp.sv
// Multi-port register file with pending-bit scoreboard and a sequential clear engine.
// Two write ports (port 1 wins on address collision), two combinational read ports.
// One pending bit per register: set by a reserve, cleared by a write (reserve wins).
// A clr pulse walks the array over NREG cycles, zeroing data and pending bits.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_FWD_EN.
module register_file_mp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic              we1,
  input  logic [AW-1:0]     wa0,
  input  logic [AW-1:0]     wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr,
  output logic              clr_busy
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [NREG-1:0]     pend_q, pend_d;

  // Next-state: port writes, scoreboard updates and the clear walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        // Port 1 is applied last so it wins a same-address collision.
        if (we0) begin
          regs_d[wa0] = wd0;
          pend_d[wa0] = 1'b0;
        end
        if (we1) begin
          regs_d[wa1] = wd1;
          pend_d[wa1] = 1'b0;
        end
        // Reserve applied after writes so it wins on the same address.
        if (rsv_en) begin
          pend_d[rsv_addr] = 1'b1;
        end
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // Port writes, reserves and clr are ignored while walking.
        regs_d[cnt_q] = '0;
        pend_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports and busy flags; forwarding applies only while idle.
  always_comb begin
    rd1   = regs_q[ra1];
    rd2   = regs_q[ra2];
    busy1 = pend_q[ra1];
    busy2 = pend_q[ra2];
`ifdef REGFILE_FWD_EN
    if (state_q == StIdle) begin
      if (we1 && (wa1 == ra1)) begin
        rd1 = wd1;
      end else if (we0 && (wa0 == ra1)) begin
        rd1 = wd0;
      end
      if (we1 && (wa1 == ra2)) begin
        rd2 = wd2_sel_dummy(wd1);
      end else if (we0 && (wa0 == ra2)) begin
        rd2 = wd0;
      end
      if (((we0 && (wa0 == ra1)) || (we1 && (wa1 == ra1))) &&
          !(rsv_en && (rsv_addr == ra1))) begin
        busy1 = 1'b0;
      end
      if (((we0 && (wa0 == ra2)) || (we1 && (wa1 == ra2))) &&
          !(rsv_en && (rsv_addr == ra2))) begin
        busy2 = 1'b0;
      end
    end
`endif
  end

`ifdef REGFILE_FWD_EN
  // Identity pass-through; keeps the two read-port forwarding paths symmetric.
  function automatic logic [DATA_W-1:0] wd2_sel_dummy(input logic [DATA_W-1:0] v);
    return v;
  endfunction
`endif

  assign clr_busy = (state_q == StClear);

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: a behavioural model predicts read data, busy
// flags and clr_busy; predictions are queued when stimulus is applied and compared when
// the outputs are sampled mid-cycle. Expectations follow REGFILE_FWD_EN if defined.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1;
  logic [2:0]  wa0, wa1;
  logic [15:0] wd0, wd1;
  logic [2:0]  ra1, ra2;
  logic [15:0] rd1, rd2;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic        busy1, busy2;
  logic        clr;
  logic        clr_busy;

  register_file_mp #(.DATA_W(16), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1), .busy2(busy2),
    .clr(clr), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  // Model state
  logic [15:0] m_reg [8];
  logic [7:0]  m_pend;
  logic        m_clr;
  logic [2:0]  m_cnt;

  logic [34:0] exp_q [$];
  logic [34:0] exp_v, obs;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_pend = '0;
    m_clr  = 1'b0;
    m_cnt  = '0;
  endfunction

  function automatic logic [15:0] m_rd(input logic [2:0] ra);
    logic [15:0] v;
    v = m_reg[ra];
`ifdef REGFILE_FWD_EN
    if (!m_clr) begin
      if (we1 && wa1 == ra) v = wd1;
      else if (we0 && wa0 == ra) v = wd0;
    end
`endif
    return v;
  endfunction

  function automatic logic m_busy(input logic [2:0] ra);
    logic b;
    b = m_pend[ra];
`ifdef REGFILE_FWD_EN
    if (!m_clr && ((we0 && wa0 == ra) || (we1 && wa1 == ra)) && !(rsv_en && rsv_addr == ra))
      b = 1'b0;
`endif
    return b;
  endfunction

  // Effect of one rising edge on the model, from the inputs currently applied.
  function automatic void m_edge();
    if (m_clr) begin
      m_reg[m_cnt]  = '0;
      m_pend[m_cnt] = 1'b0;
      if (m_cnt == 3'd7) m_clr = 1'b0;
      m_cnt = m_cnt + 3'd1;
    end else begin
      if (we0) begin m_reg[wa0] = wd0; m_pend[wa0] = 1'b0; end
      if (we1) begin m_reg[wa1] = wd1; m_pend[wa1] = 1'b0; end
      if (rsv_en) m_pend[rsv_addr] = 1'b1;
      if (clr) begin m_clr = 1'b1; m_cnt = '0; end
    end
  endfunction

  function automatic void push_exp();
    exp_q.push_back({m_rd(ra1), m_rd(ra2), m_busy(ra1), m_busy(ra2), m_clr});
  endfunction

  task automatic idle_inputs();
    we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    ra1 = 0; ra2 = 0; rsv_en = 0; rsv_addr = 0; clr = 0;
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(7 - i);
      push_exp(); #1;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL reset addr %0d: got %h want %h", i, obs, exp_v);
      end
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(i);
      push_exp(); #3;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL post_reset addr %0d: got %h want %h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  // Write then read back; also exercises write-to-read latency (same cycle vs next).
  task automatic test_write_read(input logic [2:0] a, input logic [15:0] d);
    idle_inputs();
    we0 = 1; wa0 = a; wd0 = d; ra1 = a; ra2 = a;
    for (int c = 0; c < 2; c++) begin
      push_exp(); #3;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL write_read a=%0d cyc%0d: got %h want %h", a, c, obs, exp_v);
      end
      tick();
      we0 = 0;
    end
    if (m_reg[a] !== d) begin
      n_err++; $display("FAIL write_read model a=%0d: got %h want %h", a, m_reg[a], d);
    end
  endtask

  task automatic test_same_addr();
    idle_inputs();
    we0 = 1; wa0 = 3'd5; wd0 = 16'hAAAA;
    we1 = 1; wa1 = 3'd5; wd1 = 16'h5555;
    ra1 = 3'd5; ra2 = 3'd5;
    for (int c = 0; c < 2; c++) begin
      push_exp(); #3;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL same_addr cyc%0d: got %h want %h", c, obs, exp_v);
      end
      tick();
      we0 = 0; we1 = 0;
    end
    n_vec++;
    if (rd1 !== 16'h5555) begin
      n_err++; $display("FAIL same_addr final rd1: got %h want 5555", rd1);
    end
  endtask

  task automatic test_scoreboard();
    // Per cycle: {rsv_en, we0, we1}; reserve reg2, hold, write reg2 via port 0,
    // idle, reserve+write together, idle.
    logic [2:0] seq [6];
    seq = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b101, 3'b000};
    idle_inputs();
    ra1 = 3'd2; ra2 = 3'd3; rsv_addr = 3'd2; wa0 = 3'd2; wa1 = 3'd2;
    wd0 = 16'd7; wd1 = 16'd9;
    for (int c = 0; c < 6; c++) begin
      {rsv_en, we0, we1} = seq[c];
      push_exp(); #3;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL scoreboard step%0d: got %h want %h", c, obs, exp_v);
      end
      tick();
    end
    n_vec++;
    if (busy1 !== 1'b1) begin
      n_err++; $display("FAIL scoreboard rsv_wins busy1: got %b want 1", busy1);
    end
  endtask

  // Load every register, clear, check the walk and the ignored inputs, then verify zeros.
  task automatic test_clear();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      we0 = 1; wa0 = 3'(2 * i);     wd0 = 16'h1000 + 16'(i);
      we1 = 1; wa1 = 3'(2 * i + 1); wd1 = 16'h2000 + 16'(i);
      rsv_en = (i == 3); rsv_addr = 3'd4;
      tick();
    end
    idle_inputs();
    clr = 1; ra1 = 3'd1; ra2 = 3'd4;
    push_exp(); #3;
    obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL clear start: got %h want %h", obs, exp_v);
    end
    tick();
    for (int c = 0; c < 8; c++) begin
      clr = (c == 7);
      we0 = 1; wa0 = 3'd1; wd0 = 16'hFFFF;
      rsv_en = 1; rsv_addr = 3'd3;
      ra1 = 3'(c); ra2 = 3'd1;
      push_exp(); #3;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL clear cyc%0d: got %h want %h", c, obs, exp_v);
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(i);
      push_exp(); #3;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v || obs !== 35'd0) begin
        n_err++; $display("FAIL after_clear addr %0d: got %h want %h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    we0 = 1; wa0 = 3'd6; wd0 = 16'h0BAD; rsv_en = 1; rsv_addr = 3'd7;
    tick();
    idle_inputs();
    clr = 1;
    tick();
    clr = 0;
    for (int c = 0; c < 4; c++) tick();
    #1; rst = 1; m_reset();
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(7 - i);
      push_exp(); #1;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL mid_clear_reset addr %0d: got %h want %h", i, obs, exp_v);
      end
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    ra1 = 3'd6; ra2 = 3'd7;
    for (int c = 0; c < 3; c++) begin
      push_exp(); #3;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL after_release cyc%0d: got %h want %h", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = 3'($urandom_range(0, 7)); wd0 = 16'($urandom);
      we1 = 1'($urandom_range(0, 1)); wa1 = 3'($urandom_range(0, 7)); wd1 = 16'($urandom);
      rsv_en = ($urandom_range(0, 3) == 0); rsv_addr = 3'($urandom_range(0, 7));
      ra1 = 3'($urandom_range(0, 7)); ra2 = 3'($urandom_range(0, 7));
      clr = (c == 30);
      push_exp(); #3;
      obs = {rd1, rd2, busy1, busy2, clr_busy}; exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL back_to_back cyc%0d: got %h want %h", c, obs, exp_v);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_reset();
    test_reset();
    test_write_read(3'd3, 16'h1234);
    test_write_read(3'd6, 16'hBEEF);
    test_same_addr();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter NREG, default 8, register count (power of two, >=2); AW = log2(NREG) derived as a localparam.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports we0 / we1  input  1  write enables, write ports 0 and 1.
REQ-006 SHALL have ports wa0 / wa1  input  AW  write addresses.
REQ-007 SHALL have ports wd0 / wd1  input  DATA_W  write data.
REQ-008 SHALL have ports ra1 / ra2  input  AW  read addresses.
REQ-009 SHALL have ports rd1 / rd2  output  DATA_W  read data, combinational.
REQ-010 SHALL have ports rsv_en  input  1  and rsv_addr  input  AW  to mark a register pending (scoreboard reserve).
REQ-011 SHALL have ports busy1 / busy2  output  1  pending flag for ra1 / ra2, combinational.
REQ-012 SHALL have port clr  input  1  to start a sequential clear of all registers.
REQ-013 SHALL have port clr_busy  output  1  high while a clear sequence runs.

Function
REQ-014 Reads SHALL be asynchronous: rd1 = reg[ra1] and rd2 = reg[ra2], subject to the forwarding in REQ-027.
REQ-015 In IDLE, we0 SHALL write wd0 to reg[wa0] and we1 SHALL write wd1 to reg[wa1] at the clock edge.
REQ-016 When both ports write the same address in one cycle, port 1 SHALL win; port 0 data is discarded.
REQ-017 Scoreboard: one pending bit per register; rsv_en SHALL set pend[rsv_addr] at the edge.
REQ-018 Any write (either port) SHALL clear pend[wa] at the edge.
REQ-019 When a reserve and a write hit the same address in one cycle, the reserve SHALL win (pend = 1).
REQ-020 busy1 = pend[ra1] and busy2 = pend[ra2], subject to REQ-027.
REQ-021 FSM states SHALL be IDLE and CLEAR.
REQ-022 IDLE -> CLEAR on clr=1; the clear counter SHALL load 0.
REQ-023 In CLEAR, each cycle SHALL write 0 to reg[cnt], clear pend[cnt] and increment cnt; after cnt = NREG-1 the FSM SHALL return to IDLE.
REQ-024 A clear sequence SHALL take exactly NREG cycles; clr_busy is high for exactly those NREG cycles.
REQ-025 In CLEAR, we0/we1, rsv_en and clr SHALL be ignored (no effect, no queuing).
REQ-026 In CLEAR, reads SHALL return stored array contents with no forwarding, and busy SHALL follow the stored pend bits.

Reset
REQ-027 Macro REGFILE_FWD_EN defined: in IDLE, rd SHALL return wd1 if we1 && wa1 == ra, else wd0 if we0 && wa0 == ra, else reg[ra]; busy SHALL be 0 when either port writes ra that cycle, unless rsv_en && rsv_addr == ra.
REQ-028 rst=1 SHALL immediately, without waiting for clk, set all registers to 0, all pend bits to 0, the FSM to IDLE, cnt to 0, and clr_busy to 0.
REQ-029 Deasserting rst during a clear sequence SHALL leave the FSM in IDLE; the sequence is not resumed.
REQ-030 Out of reset, rd1, rd2, busy1 and busy2 SHALL be 0 for every address.

Configuration
REQ-031 With REGFILE_FWD_EN undefined, no forwarding SHALL occur: reads and busy reflect only state updated at the prior edge, giving a one-cycle write-to-read latency.

Verification
REQ-032 Scenario: reset, write reg3=0x1234 via port 0, read ra1=3 next cycle -> rd1=0x1234, busy1=0.
REQ-033 Scenario: we0 and we1 both write reg5 with 0xAAAA and 0x5555 -> reg5=0x5555. With FWD, rd1(ra1=5) SHALL be 0x5555 in the same cycle.
REQ-034 Scenario: rsv reg2 -> busy1(ra1=2)=1; later write reg2=7 -> busy1=0 after the edge (same cycle with FWD). Reserve and write reg2 together -> busy stays 1.
REQ-035 Scenario: load all regs nonzero, pulse clr -> clr_busy=1 for 8 cycles; a we0 to reg1 during CLEAR is ignored; afterwards all regs read 0 and no pend bits are set.
REQ-036 Scenario: assert rst mid-clear at cnt=4 -> all outputs 0 at once, clr_busy=0, FSM IDLE after release.
REQ-037 Scenario: build without REGFILE_FWD_EN, write reg6=0xBEEF with ra1=6 -> rd1 = old value that cycle and 0xBEEF the next cycle.
